// File: rtl/cpu_mode_ctrl.sv
// Board mode sequencer: IDLE -> PROG (UART load, with timeout) -> LOADED -> RUN.
// Drives the UART programmer reset, CPU reset/inited and the CPU clock-enable.
module cpu_mode_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
   parameter int unsigned CNT_W          = 28
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_prog,
   input  logic       btn_enter,
   input  logic       btn_step,
   input  logic       step_mode,
   input  logic       upg_wen_i,
   input  logic       upg_done_i,
   output logic       upg_rst_o,
   output logic       cpu_rst_o,
   output logic       cpu_run_o,
   output logic       inited_o,
   output logic [1:0] mode_o,
   output logic       prog_err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      PROG   = 2'b01,
      LOADED = 2'b10,
      RUN    = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prog_prev_q, prog_prev_d;
   logic             enter_prev_q, enter_prev_d;
   logic             step_prev_q, step_prev_d;
   logic             run_q, run_d;
   logic             err_q, err_d;

   logic             prog_rise;
   logic             enter_rise;
   logic             step_rise;
   logic             timeout;

   always_comb begin
      prog_prev_d  = btn_prog;
      enter_prev_d = btn_enter;
      step_prev_d  = btn_step;
      prog_rise    = btn_prog  & ~prog_prev_q;
      enter_rise   = btn_enter & ~enter_prev_q;
      step_rise    = btn_step  & ~step_prev_q;
   end

   always_comb begin
      state_d = state_q;
      timeout = 1'b0;
      case (state_q)
         IDLE, LOADED: begin
            if (prog_rise) begin
               state_d = PROG;
            end else if (enter_rise) begin
               state_d = RUN;
            end
         end
         PROG: begin
            // A finished load beats a timeout on the same cycle.
            if (upg_done_i) begin
               state_d = LOADED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               timeout = 1'b1;
            end
         end
         RUN: begin
            if (prog_rise) begin
               state_d = PROG;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = '0;
      if (state_d == PROG && state_q == PROG && !upg_wen_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_comb begin
      err_d = err_q;
      if (timeout) begin
         err_d = 1'b1;
      end else if (prog_rise) begin
         err_d = 1'b0;
      end
   end

   // Looking at both current and next state keeps the enable low on entry to
   // RUN and drops it on the same edge that leaves RUN.
   always_comb begin
      run_d = 1'b0;
      if (state_q == RUN && state_d == RUN) begin
         run_d = step_mode ? step_rise : 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         prog_prev_q  <= 1'b0;
         enter_prev_q <= 1'b0;
         step_prev_q  <= 1'b0;
         run_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         prog_prev_q  <= prog_prev_d;
         enter_prev_q <= enter_prev_d;
         step_prev_q  <= step_prev_d;
         run_q        <= run_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      upg_rst_o  = (state_q != PROG);
      cpu_rst_o  = (state_q != RUN);
      inited_o   = (state_q == RUN);
      mode_o     = state_q;
      cpu_run_o  = run_q;
      prog_err_o = err_q;
   end

endmodule

// File: tb/tb_cpu_mode_ctrl.sv
// Directed mode-sequencing scenarios followed by random button/UART activity,
// every cycle compared against a behavioural model of the mode rules.
module tb_cpu_mode_ctrl;

   localparam int TMO = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_prog = 1'b0;
   logic       btn_enter = 1'b0;
   logic       btn_step = 1'b0;
   logic       step_mode = 1'b0;
   logic       upg_wen_i = 1'b0;
   logic       upg_done_i = 1'b0;
   logic       upg_rst_o;
   logic       cpu_rst_o;
   logic       cpu_run_o;
   logic       inited_o;
   logic [1:0] mode_o;
   logic       prog_err_o;

   int vectors = 0;
   int miscompares = 0;

   // Model: mode as 0=IDLE 1=PROG 2=LOADED 3=RUN, quiet = PROG cycles since entry/last write.
   int m_mode = 0;
   int m_quiet = 0;
   bit m_err = 1'b0;
   bit m_run = 1'b0;
   bit pp = 1'b0, pe = 1'b0, ps = 1'b0;

   cpu_mode_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_prog   (btn_prog),
      .btn_enter  (btn_enter),
      .btn_step   (btn_step),
      .step_mode  (step_mode),
      .upg_wen_i  (upg_wen_i),
      .upg_done_i (upg_done_i),
      .upg_rst_o  (upg_rst_o),
      .cpu_rst_o  (cpu_rst_o),
      .cpu_run_o  (cpu_run_o),
      .inited_o   (inited_o),
      .mode_o     (mode_o),
      .prog_err_o (prog_err_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic model_step();
      bit rp, re, rs, tmo;
      int nm;
      if (reset) begin
         m_mode = 0; m_quiet = 0; m_err = 1'b0; m_run = 1'b0;
         pp = 1'b0; pe = 1'b0; ps = 1'b0;
         return;
      end
      rp = btn_prog && !pp;
      re = btn_enter && !pe;
      rs = btn_step && !ps;
      tmo = 1'b0;
      nm = m_mode;
      if (m_mode == 1) begin
         if (upg_done_i) nm = 2;
         else if (m_quiet == TMO - 1) begin nm = 0; tmo = 1'b1; end
      end else if (rp) begin
         nm = 1;
      end else if (re && m_mode != 3) begin
         nm = 3;
      end
      m_run = (m_mode == 3) && (nm == 3) && (!step_mode || rs);
      if (tmo) m_err = 1'b1;
      else if (rp) m_err = 1'b0;
      if (m_mode == 1 && nm == 1 && !upg_wen_i) m_quiet++;
      else m_quiet = 0;
      m_mode = nm;
      pp = btn_prog; pe = btn_enter; ps = btn_step;
   endtask

   function automatic logic [7:0] model_outs();
      logic [1:0] md;
      md = 2'(m_mode);
      return {1'b0, md, (m_mode != 1), (m_mode != 3), m_run, (m_mode == 3), m_err};
   endfunction

   task automatic tick(input string tag);
      model_step();
      @(posedge clock);
      #1;
      chk(tag, {1'b0, mode_o, upg_rst_o, cpu_rst_o, cpu_run_o, inited_o, prog_err_o}, model_outs());
   endtask

   initial begin
      int pulses;

      // T1: reset, then program load
      tick("rst0");
      tick("rst1");
      chk("rst_mode", {6'd0, mode_o}, 8'd0);
      chk("rst_run_err", {6'd0, cpu_run_o, prog_err_o}, 8'd0);
      reset = 1'b0;
      tick("idle");
      btn_prog = 1'b1;
      tick("t1_prog");
      chk("t1_mode", {6'd0, mode_o}, 8'd1);
      chk("t1_upg_rst", {7'd0, upg_rst_o}, 8'd0);
      btn_prog = 1'b0;
      upg_done_i = 1'b1;
      tick("t1_done");
      chk("t1_loaded", {5'd0, mode_o, upg_rst_o}, 8'b101);
      upg_done_i = 1'b0;

      // T2: start CPU in free-run
      btn_enter = 1'b1;
      tick("t2_enter");
      chk("t2_run_state", {4'd0, mode_o, cpu_rst_o, inited_o}, 8'b1101);
      chk("t2_run_first", {7'd0, cpu_run_o}, 8'd0);
      btn_enter = 1'b0;
      tick("t2_run");
      chk("t2_run_on", {7'd0, cpu_run_o}, 8'd1);

      // T6a: reset in RUN
      reset = 1'b1;
      tick("t6_rst_run");
      chk("t6_run_idle", {3'd0, mode_o, upg_rst_o, cpu_rst_o, prog_err_o}, 8'b00110);
      reset = 1'b0;
      tick("t6_release");

      // T3: programming timeout with one write at cycle 10
      btn_prog = 1'b1;
      tick("t3_enter");
      btn_prog = 1'b0;
      repeat (9) tick("t3_wait");
      upg_wen_i = 1'b1;
      tick("t3_wen");
      upg_wen_i = 1'b0;
      repeat (15) tick("t3_quiet");
      chk("t3_still_prog", {6'd0, mode_o}, 8'd1);
      tick("t3_timeout");
      chk("t3_abort", {5'd0, mode_o, prog_err_o}, 8'b001);

      // T5a: prog+enter together from IDLE, prog wins and clears the error
      btn_prog = 1'b1;
      btn_enter = 1'b1;
      tick("t5_both");
      chk("t5_prog_wins", {5'd0, mode_o, prog_err_o}, 8'b010);
      btn_prog = 1'b0;
      btn_enter = 1'b0;
      upg_done_i = 1'b1;
      tick("t5_done");
      upg_done_i = 1'b0;
      btn_enter = 1'b1;
      tick("t5_enter");
      btn_enter = 1'b0;

      // T4: single-step, three presses 5 cycles apart
      step_mode = 1'b1;
      pulses = 0;
      repeat (3) begin
         btn_step = 1'b1;
         tick("t4_press");
         pulses += int'(cpu_run_o);
         btn_step = 1'b0;
         repeat (4) begin
            tick("t4_gap");
            pulses += int'(cpu_run_o);
         end
      end
      chk("t4_pulses", 8'(pulses), 8'd3);

      // T5b: prog rise in RUN resets the CPU immediately
      step_mode = 1'b0;
      tick("t5_freerun");
      btn_prog = 1'b1;
      tick("t5_run_prog");
      chk("t5_run_to_prog", {4'd0, mode_o, cpu_rst_o, cpu_run_o}, 8'b0110);
      btn_prog = 1'b0;

      // T6b: reset in PROG
      tick("t6_prog");
      reset = 1'b1;
      tick("t6_rst_prog");
      chk("t6_prog_idle", {3'd0, mode_o, upg_rst_o, cpu_rst_o, prog_err_o}, 8'b00110);
      reset = 1'b0;

      // Random activity against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) btn_prog = ~btn_prog;
         if ($urandom_range(0, 4) == 0) btn_enter = ~btn_enter;
         if ($urandom_range(0, 2) == 0) btn_step = ~btn_step;
         if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
         upg_wen_i = ($urandom_range(0, 7) == 0);
         upg_done_i = ($urandom_range(0, 11) == 0);
         reset = ($urandom_range(0, 299) == 0);
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
